gpio_input_filter_bank: RTL and testbench

//  Multi-channel GPIO input conditioning stage: per-channel N-flop synchronizer, optional

---
 rtl/gpio_input_filter_bank.sv | 113 +++++++++++
 tb/tb_gpio_input_filter_bank.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_filter_bank.sv
`default_nettype none
// ============================================================================
// Module   : gpio_input_filter_bank
// Purpose  : Per-channel pad synchronizer, debounce filter, edge detect and
//            sticky interrupt status for a GPIO block.
// Revision : 1.0
// ============================================================================
module gpio_input_filter_bank #(
   parameter int NrChannels   = 32,
   parameter int NrSyncStages = 2,
   parameter int CntWidth     = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NrChannels-1:0]   serial_i,
   input  logic [NrChannels-1:0]   en_i,
   input  logic [NrChannels-1:0]   dbnc_en_i,
   input  logic [CntWidth-1:0]     dbnc_cycles_i,
   input  logic [NrChannels-1:0]   irq_en_i,
   input  logic [2*NrChannels-1:0] irq_mode_i,
   input  logic [NrChannels-1:0]   irq_clr_i,
   output logic [NrChannels-1:0]   serial_o,
   output logic [NrChannels-1:0]   r_edge_o,
   output logic [NrChannels-1:0]   f_edge_o,
   output logic [NrChannels-1:0]   irq_status_o,
   output logic                    irq_o
);

   localparam logic [1:0] ModeRise  = 2'b00;
   localparam logic [1:0] ModeFall  = 2'b01;
   localparam logic [1:0] ModeBoth  = 2'b10;
   localparam logic [1:0] ModeLevel = 2'b11;

   logic [NrChannels-1:0] sync_q [NrSyncStages];
   logic [NrChannels-1:0] sync_d [NrSyncStages];
   logic [NrChannels-1:0] sync_out;
   logic [CntWidth-1:0]   cnt_q  [NrChannels];
   logic [CntWidth-1:0]   cnt_d  [NrChannels];
   logic [NrChannels-1:0] filt_q, filt_d;
   logic [NrChannels-1:0] r_edge_q, r_edge_d;
   logic [NrChannels-1:0] f_edge_q, f_edge_d;
   logic [NrChannels-1:0] status_q, status_d;
   logic [NrChannels-1:0] evt;
   logic [CntWidth-1:0]   thr_dbnc;

   // Thresholds of 0 and 1 both collapse to a single-cycle bypass.
   assign thr_dbnc = (dbnc_cycles_i > CntWidth'(1)) ? dbnc_cycles_i : CntWidth'(1);
   assign sync_out = sync_q[NrSyncStages-1];

   always_comb begin
      sync_d[0] = serial_i;
      for (int s = 1; s < NrSyncStages; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   always_comb begin
      filt_d = filt_q;
      evt    = '0;
      for (int i = 0; i < NrChannels; i++) begin
         cnt_d[i] = '0;
         // Comparing with >= lets a threshold lowered mid-count fire at once.
         if (sync_out[i] != filt_q[i]) begin
            if (({1'b0, cnt_q[i]} + (CntWidth+1)'(1)) >=
                {1'b0, (dbnc_en_i[i] ? thr_dbnc : CntWidth'(1))}) begin
               filt_d[i] = ~filt_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end
         end
         case (irq_mode_i[2*i +: 2])
            ModeRise:  evt[i] = r_edge_q[i];
            ModeFall:  evt[i] = f_edge_q[i];
            ModeBoth:  evt[i] = r_edge_q[i] | f_edge_q[i];
            ModeLevel: evt[i] = filt_q[i];
            default:   evt[i] = 1'b0;
         endcase
      end
      r_edge_d = filt_d & ~filt_q & en_i;
      f_edge_d = ~filt_d & filt_q & en_i;
      status_d = (status_q & ~irq_clr_i) | (irq_en_i & en_i & evt);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < NrSyncStages; s++) begin
            sync_q[s] <= '0;
         end
         for (int i = 0; i < NrChannels; i++) begin
            cnt_q[i] <= '0;
         end
         filt_q   <= '0;
         r_edge_q <= '0;
         f_edge_q <= '0;
         status_q <= '0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         filt_q   <= filt_d;
         r_edge_q <= r_edge_d;
         f_edge_q <= f_edge_d;
         status_q <= status_d;
      end
   end

   assign serial_o     = filt_q;
   assign r_edge_o     = r_edge_q;
   assign f_edge_o     = f_edge_q;
   assign irq_status_o = status_q;
   assign irq_o        = |status_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_filter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_input_filter_bank
// Purpose  : Directed vector bench for gpio_input_filter_bank.
// Revision : 1.0
// ============================================================================
module tb_gpio_input_filter_bank;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] serial_i, en_i, dbnc_en_i, irq_en_i, irq_clr_i;
   logic [63:0] irq_mode_i;
   logic [7:0]  dbnc_cycles_i;
   logic [31:0] serial_o, r_edge_o, f_edge_o, irq_status_o;
   logic        irq_o;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] s;
      logic [3:0] clr;
      logic [3:0] so;
      logic [3:0] re;
      logic [3:0] fe;
      logic [3:0] st;
      logic       irq;
   } vec_t;

   vec_t tbl [18];

   gpio_input_filter_bank dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .serial_i      (serial_i),
      .en_i          (en_i),
      .dbnc_en_i     (dbnc_en_i),
      .dbnc_cycles_i (dbnc_cycles_i),
      .irq_en_i      (irq_en_i),
      .irq_mode_i    (irq_mode_i),
      .irq_clr_i     (irq_clr_i),
      .serial_o      (serial_o),
      .r_edge_o      (r_edge_o),
      .f_edge_o      (f_edge_o),
      .irq_status_o  (irq_status_o),
      .irq_o         (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " serial_o"}, serial_o, 32'h0);
      check({tag, " r_edge_o"}, r_edge_o, 32'h0);
      check({tag, " f_edge_o"}, f_edge_o, 32'h0);
      check({tag, " status"},   irq_status_o, 32'h0);
      check({tag, " irq_o"},    {31'h0, irq_o}, 32'h0);
   endtask

   logic       flag, flag2;
   logic [15:0] so_h, re_h, fe_h;
   int         re_cnt, fe_cnt;

   initial begin
      // Ch0..3 in modes rise/fall/both/level, bypass filter, 1-cycle pulse then clears.
      //            s     clr   so    re    fe    st    irq
      tbl[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[1]  = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[2]  = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[3]  = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0};
      tbl[4]  = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hD, 1'b1};
      tbl[5]  = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hD, 1'b1};
      tbl[6]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hD, 1'b1};
      tbl[7]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1};
      tbl[8]  = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[9]  = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[10] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[11] = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0};
      tbl[12] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hD, 1'b1};
      tbl[13] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hD, 1'b1};
      tbl[14] = '{4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h8, 1'b1};
      tbl[15] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h8, 1'b1};
      tbl[16] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hE, 1'b1};
      tbl[17] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

      rst_i         = 1'b1;
      serial_i      = '0;
      en_i          = 32'h0000_000F;
      dbnc_en_i     = '0;
      dbnc_cycles_i = 8'd5;
      irq_en_i      = 32'h0000_000F;
      irq_mode_i    = 64'h0000_0000_0000_00E4;
      irq_clr_i     = '0;
      repeat (3) step();
      check_all_zero("reset");

      rst_i = 1'b0;
      for (int t = 0; t < 18; t++) begin
         serial_i[3:0]  = tbl[t].s;
         irq_clr_i[3:0] = tbl[t].clr;
         step();
         check($sformatf("v%0d serial_o", t), serial_o,     {28'h0, tbl[t].so});
         check($sformatf("v%0d r_edge_o", t), r_edge_o,     {28'h0, tbl[t].re});
         check($sformatf("v%0d f_edge_o", t), f_edge_o,     {28'h0, tbl[t].fe});
         check($sformatf("v%0d status", t),   irq_status_o, {28'h0, tbl[t].st});
         check($sformatf("v%0d irq_o", t),    {31'h0, irq_o}, {31'h0, tbl[t].irq});
      end
      irq_clr_i = '0;

      // Debounce on ch4, threshold 5: a 4-cycle glitch must vanish.
      en_i[4]      = 1'b1;
      dbnc_en_i[4] = 1'b1;
      flag = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         serial_i[4] = (k <= 4);
         step();
         flag |= serial_o[4] | r_edge_o[4] | f_edge_o[4];
      end
      check("dbnc glitch", {31'h0, flag}, 32'h0);

      so_h = '0; re_h = '0; fe_h = '0; re_cnt = 0; fe_cnt = 0;
      for (int k = 1; k <= 15; k++) begin
         serial_i[4] = (k <= 5);
         step();
         so_h[k] = serial_o[4];
         re_h[k] = r_edge_o[4];
         fe_h[k] = f_edge_o[4];
         re_cnt += int'(r_edge_o[4]);
         fe_cnt += int'(f_edge_o[4]);
      end
      check("dbnc so@6",  {31'h0, so_h[6]},  32'h0);
      check("dbnc so@7",  {31'h0, so_h[7]},  32'h1);
      check("dbnc re@7",  {31'h0, re_h[7]},  32'h1);
      check("dbnc so@11", {31'h0, so_h[11]}, 32'h1);
      check("dbnc so@12", {31'h0, so_h[12]}, 32'h0);
      check("dbnc fe@12", {31'h0, fe_h[12]}, 32'h1);
      check("dbnc re count", re_cnt, 32'd1);
      check("dbnc fe count", fe_cnt, 32'd1);

      // Ch5 disabled while toggling, then enabled with a steady high input.
      irq_en_i[5]       = 1'b1;
      irq_mode_i[11:10] = 2'b10;
      flag = 1'b0;
      for (int k = 0; k < 12; k++) begin
         serial_i[5] = ((k / 3) % 2 == 0);
         step();
         flag |= r_edge_o[5] | f_edge_o[5] | irq_status_o[5];
      end
      serial_i[5] = 1'b1;
      repeat (6) begin
         step();
         flag |= r_edge_o[5] | f_edge_o[5] | irq_status_o[5];
      end
      check("disabled edges", {31'h0, flag}, 32'h0);
      en_i[5] = 1'b1;
      flag2 = 1'b0;
      repeat (8) begin
         step();
         flag2 |= r_edge_o[5] | f_edge_o[5] | irq_status_o[5];
      end
      check("enable no stale edge", {31'h0, flag2}, 32'h0);
      check("enable serial_o5", {31'h0, serial_o[5]}, 32'h1);

      // Ch6 reset mid-count with input held high across reset release.
      en_i[6]        = 1'b1;
      dbnc_en_i[6]   = 1'b1;
      irq_en_i[6]    = 1'b1;
      irq_mode_i[13:12] = 2'b00;
      serial_i[6]    = 1'b1;
      repeat (4) step();
      rst_i = 1'b1;
      step();
      check_all_zero("midreset");
      rst_i = 1'b0;
      so_h = '0; re_h = '0; re_cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         so_h[k] = serial_o[6];
         re_h[k] = r_edge_o[6];
         re_cnt += int'(r_edge_o[6]);
         if (k == 8) begin
            check("rst status6@8", {31'h0, irq_status_o[6]}, 32'h1);
            check("rst irq_o@8",   {31'h0, irq_o}, 32'h1);
         end
      end
      check("rst so@6",  {31'h0, so_h[6]}, 32'h0);
      check("rst so@7",  {31'h0, so_h[7]}, 32'h1);
      check("rst re@7",  {31'h0, re_h[7]}, 32'h1);
      check("rst re count", re_cnt, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
